// File: rtl/perspective_divide_sequencer_if.sv
// Bus bundle for perspective_divide_sequencer: upstream vertex handshake,
// shared divide-unit operands/result, and downstream NDC vertex handshake.
interface perspective_divide_sequencer_if;
    logic             valid_in;
    logic             ready_out;
    logic [3:0][31:0] vertex_in;
    logic             div_start_out;
    logic [31:0]      div_dividend_out;
    logic [31:0]      div_divisor_out;
    logic             div_done_in;
    logic [31:0]      div_quotient_in;
    logic             valid_out;
    logic             ready_in;
    logic [3:0][31:0] vertex_out;

    modport slave (
        input  valid_in, vertex_in, div_done_in, div_quotient_in, ready_in,
        output ready_out, div_start_out, div_dividend_out, div_divisor_out,
        output valid_out, vertex_out
    );

    modport master (
        output valid_in, vertex_in, div_done_in, div_quotient_in, ready_in,
        input  ready_out, div_start_out, div_dividend_out, div_divisor_out,
        input  valid_out, vertex_out
    );
endinterface

// File: rtl/perspective_divide_sequencer.sv
// Perspective-divide sequencer: shares one external divider across lanes 0..NUM_DIV_LANES-1.
// Optional PERSPECTIVE_DIVIDE_ZERO_W_EN bypasses the divider when w is +/-0.0.
module perspective_divide_sequencer #(
    parameter int unsigned NUM_DIV_LANES = 3,
    parameter int unsigned W_LANE        = 3
) (
    input logic                           clk_in,
    input logic                           rst_in,
    perspective_divide_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

    localparam logic [1:0] LAST_IDX = 2'(NUM_DIV_LANES - 1);
    localparam logic [1:0] W_IDX    = 2'(W_LANE);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][31:0] cap_q, cap_d;
    logic [3:0][31:0] res_q, res_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cap_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            res_q   <= res_d;
        end
    end

    // Operands come from the untouched capture copy; results accumulate in a
    // separate copy so an early quotient never corrupts a later operand or w.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    cap_d   = bus.vertex_in;
                    res_d   = bus.vertex_in;
                    idx_d   = '0;
                    state_d = ISSUE;
`ifdef PERSPECTIVE_DIVIDE_ZERO_W_EN
                    if (bus.vertex_in[W_IDX][30:0] == '0) begin
                        for (int unsigned i = 0; i < NUM_DIV_LANES; i++) begin
                            res_d[i[1:0]] = '0;
                        end
                        state_d = OUTPUT;
                    end
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.div_done_in) begin
                    res_d[idx_q] = bus.div_quotient_in;
                    if (idx_q == LAST_IDX) begin
                        state_d = OUTPUT;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ISSUE;
                    end
                end
            end
            OUTPUT: begin
                if (bus.ready_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ready_out is gated by reset so it drops asynchronously with rst_in.
    assign bus.ready_out        = (state_q == IDLE) && !rst_in;
    assign bus.div_start_out    = (state_q == ISSUE);
    assign bus.div_dividend_out = cap_q[idx_q];
    assign bus.div_divisor_out  = cap_q[W_IDX];
    assign bus.valid_out        = (state_q == OUTPUT);
    assign bus.vertex_out       = res_q;
endmodule

// File: tb/tb_perspective_divide_sequencer.sv
// Directed bench for perspective_divide_sequencer with a table-driven divider model
// (per-lane latency and hand-computed quotients); honours PERSPECTIVE_DIVIDE_ZERO_W_EN.
module tb_perspective_divide_sequencer;
    logic clk;
    logic rst;

    perspective_divide_sequencer_if bus();

    perspective_divide_sequencer #(
        .NUM_DIV_LANES(3),
        .W_LANE       (3)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Divider model state
    int unsigned lat [3];
    logic [31:0] qt  [3];
    int unsigned n_starts;
    int unsigned n_done;
    int unsigned cnt;
    int unsigned unstable;
    logic [31:0] rec_div [8];
    logic [31:0] rec_dvs [8];
    logic        model_done;
    logic [31:0] model_q;
    logic        spur_done;
    logic [31:0] spur_q;

    assign bus.div_done_in     = model_done | spur_done;
    assign bus.div_quotient_in = spur_done ? spur_q : model_q;

    initial begin
        model_done = 1'b0;
        model_q    = '0;
        cnt        = 0;
        n_starts   = 0;
        n_done     = 0;
        unstable   = 0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt != 0) begin
                    if (bus.div_dividend_out !== rec_div[(n_starts - 1) % 8] ||
                        bus.div_divisor_out  !== rec_dvs[(n_starts - 1) % 8])
                        unstable++;
                    cnt--;
                    if (cnt == 0) begin
                        model_done = 1'b1;
                        model_q    = qt[n_done % 3];
                        n_done++;
                    end
                end
                if (bus.div_start_out === 1'b1) begin
                    rec_div[n_starts % 8] = bus.div_dividend_out;
                    rec_dvs[n_starts % 8] = bus.div_divisor_out;
                    cnt = lat[n_starts % 3];
                    n_starts++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_div(input int unsigned l0, input int unsigned l1, input int unsigned l2,
                           input logic [31:0] q0, input logic [31:0] q1, input logic [31:0] q2);
        lat[0] = l0; lat[1] = l1; lat[2] = l2;
        qt[0]  = q0; qt[1]  = q1; qt[2]  = q2;
        n_starts = 0;
        n_done   = 0;
        unstable = 0;
    endtask

    task automatic send(input logic [127:0] v);
        bus.vertex_in = v;
        bus.valid_in  = 1'b1;
        @(negedge clk);
        bus.valid_in  = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (bus.valid_out !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    localparam logic [127:0] V_BASIC = {32'h40000000, 32'hC0000000, 32'h41000000, 32'h40800000};
    localparam logic [127:0] R_BASIC = {32'h40000000, 32'hBF800000, 32'h40800000, 32'h40000000};
    localparam logic [127:0] V_BP    = {32'h40A00000, 32'h3F800000, 32'hC1200000, 32'h41200000};
    localparam logic [127:0] R_BP    = {32'h40A00000, 32'h3E4CCCCD, 32'hC0000000, 32'h40000000};
    localparam logic [127:0] V_SP    = {32'h40800000, 32'h40A00000, 32'h40400000, 32'h3F800000};
    localparam logic [127:0] V_ZW    = {32'h80000000, 32'h40400000, 32'h40000000, 32'h3F800000};

    initial begin
        int cyc;
        int hold_err;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        spur_done = 1'b0;
        spur_q    = '0;
        bus.valid_in  = 1'b0;
        bus.vertex_in = '0;
        bus.ready_in  = 1'b1;
        set_div(1, 1, 1, 32'h0, 32'h0, 32'h0);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(bus.ready_out), 128'd0);
        chk("rst_valid", 128'(bus.valid_out), 128'd0);
        chk("rst_start", 128'(bus.div_start_out), 128'd0);
        chk("rst_operands", {64'd0, bus.div_dividend_out, bus.div_divisor_out}, 128'd0);
        chk("rst_vertex", bus.vertex_out, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 128'(bus.ready_out), 128'd1);

        // Basic vertex, L=1
        set_div(1, 1, 1, 32'h40000000, 32'h40800000, 32'hBF800000);
        send(V_BASIC);
        wait_valid(cyc);
        chk("basic_latency", 128'(cyc), 128'd7);
        chk("basic_vertex", bus.vertex_out, R_BASIC);
        chk("basic_starts", 128'(n_starts), 128'd3);
        chk("basic_dividends", {32'd0, rec_div[2], rec_div[1], rec_div[0]},
            {32'd0, 32'hC0000000, 32'h41000000, 32'h40800000});
        chk("basic_divisors", {32'd0, rec_dvs[2], rec_dvs[1], rec_dvs[0]},
            {32'd0, 32'h40000000, 32'h40000000, 32'h40000000});
        @(negedge clk);
        chk("basic_done_valid", 128'(bus.valid_out), 128'd0);
        chk("basic_done_ready", 128'(bus.ready_out), 128'd1);

        // Variable latency 5/1/12
        set_div(5, 1, 12, 32'h40000000, 32'h40800000, 32'hBF800000);
        send(V_BASIC);
        wait_valid(cyc);
        chk("varlat_latency", 128'(cyc), 128'd22);
        chk("varlat_vertex", bus.vertex_out, R_BASIC);
        chk("varlat_starts", 128'(n_starts), 128'd3);
        chk("varlat_stable", 128'(unstable), 128'd0);
        @(negedge clk);

        // Backpressure in OUTPUT
        bus.ready_in = 1'b0;
        set_div(1, 1, 1, 32'h40000000, 32'hC0000000, 32'h3E4CCCCD);
        send(V_BP);
        wait_valid(cyc);
        chk("bp_latency", 128'(cyc), 128'd7);
        chk("bp_vertex", bus.vertex_out, R_BP);
        bus.vertex_in = V_BASIC;
        bus.valid_in  = 1'b1;
        hold_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.valid_out !== 1'b1 || bus.vertex_out !== R_BP || bus.ready_out !== 1'b0)
                hold_err++;
        end
        chk("bp_hold", 128'(hold_err), 128'd0);
        chk("bp_no_accept", 128'(n_starts), 128'd3);
        bus.ready_in = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 128'(bus.valid_out), 128'd0);
        chk("bp_release_ready", 128'(bus.ready_out), 128'd1);
        chk("bp_handshake_no_accept", 128'(n_starts), 128'd3);
        bus.valid_in = 1'b0;
        @(negedge clk);

        // Spurious done in IDLE
        spur_done = 1'b1;
        spur_q    = 32'hDEADBEEF;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_idle_ready", 128'(bus.ready_out), 128'd1);
        chk("spur_idle_vertex", bus.vertex_out, R_BP);
        chk("spur_idle_starts", 128'(n_starts), 128'd3);

        // Asynchronous reset during ISSUE
        set_div(1, 1, 1, 32'h1, 32'h2, 32'h3);
        send(V_BASIC);
        chk("issue_start", 128'(bus.div_start_out), 128'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_start", 128'(bus.div_start_out), 128'd0);
        chk("async_ready", 128'(bus.ready_out), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("issue_rst_ready", 128'(bus.ready_out), 128'd1);

        // Spurious done in ISSUE, then reset during WAIT of lane 1
        set_div(3, 3, 3, 32'h11111111, 32'h22222222, 32'h33333333);
        send(V_SP);
        chk("sp_issue_start", 128'(bus.div_start_out), 128'd1);
        spur_done = 1'b1;
        spur_q    = 32'hDEADBEEF;
        @(negedge clk);
        spur_done = 1'b0;
        chk("sp_issue_lane0", 128'(bus.vertex_out[0]), 128'h3F800000);
        chk("sp_issue_to_wait", 128'(bus.div_start_out), 128'd0);
        repeat (4) @(negedge clk);
        chk("wait1_dividend", 128'(bus.div_dividend_out), 128'h40400000);
        chk("wait1_lane0", 128'(bus.vertex_out[0]), 128'h11111111);
        #1 rst = 1'b1;
        #1;
        chk("wait_rst_vertex", bus.vertex_out, 128'd0);
        chk("wait_rst_dividend", 128'(bus.div_dividend_out), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_div(1, 1, 1, 32'h40000000, 32'h40800000, 32'hBF800000);
        send(V_BASIC);
        wait_valid(cyc);
        chk("recover_latency", 128'(cyc), 128'd7);
        chk("recover_first_dividend", 128'(rec_div[0]), 128'h40800000);
        chk("recover_vertex", bus.vertex_out, R_BASIC);
        @(negedge clk);

        // Zero w (negative zero)
        bus.ready_in = 1'b0;
        set_div(1, 1, 1, 32'h7F800000, 32'h7F800001, 32'h7F800002);
        send(V_ZW);
        wait_valid(cyc);
`ifdef PERSPECTIVE_DIVIDE_ZERO_W_EN
        chk("zw_latency", 128'(cyc), 128'd1);
        chk("zw_starts", 128'(n_starts), 128'd0);
        chk("zw_vertex", bus.vertex_out, {32'h80000000, 96'd0});
`else
        chk("zw_latency", 128'(cyc), 128'd7);
        chk("zw_starts", 128'(n_starts), 128'd3);
        chk("zw_vertex", bus.vertex_out, {32'h80000000, 32'h7F800002, 32'h7F800001, 32'h7F800000});
`endif
        // Asynchronous reset while stalled in OUTPUT
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("out_rst_valid", 128'(bus.valid_out), 128'd0);
        chk("out_rst_vertex", bus.vertex_out, 128'd0);
        chk("out_rst_ready", 128'(bus.ready_out), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.ready_in = 1'b1;
        @(negedge clk);
        chk("final_ready", 128'(bus.ready_out), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
